// File: rtl/rgb_duty_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_duty_decoder
//  Description : Receive side of the active-low 3-bit time-multiplexed RGB
//                LED drive. Counts lit samples per channel over fixed,
//                back-to-back windows and presents scaled R/G/B intensity
//                words through a valid/ready hold register.
//                Optional build macro RGB_DEC_SYNC_EN inserts a 2-flop
//                input synchronizer for asynchronous pin sources.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_duty_decoder #(
  parameter int WINDOW_TICKS = 4096,
  parameter int SAMPLE_DIV   = 1,
  parameter int OUT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       led_in,
  input  logic             color_ready,
  output logic [OUT_W-1:0] red,
  output logic [OUT_W-1:0] green,
  output logic [OUT_W-1:0] blue,
  output logic             color_valid,
  output logic             overrun
);

  localparam int LOG2_W = $clog2(WINDOW_TICKS);
  localparam int ACC_W  = LOG2_W + 1;
  localparam int SHIFT  = LOG2_W - OUT_W;
  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  // Led bit index per colour: [2]=R, [1]=B, [0]=G
  localparam int CH_R = 2;
  localparam int CH_B = 1;
  localparam int CH_G = 0;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [2:0]       led_s;
  logic [DIV_W-1:0] div_q;
  logic [LOG2_W-1:0] cnt_q;
  logic             tick;
  logic             win_end;
  logic [ACC_W-1:0] acc_q  [3];
  logic [ACC_W-1:0] acc_d  [3];
  logic [OUT_W-1:0] scaled [3];

  state_t           state_q;
  logic             valid_q;
  logic             overrun_q;
  logic [OUT_W-1:0] red_q;
  logic [OUT_W-1:0] green_q;
  logic [OUT_W-1:0] blue_q;

`ifdef RGB_DEC_SYNC_EN
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  // Two-stage synchronizer; left unreset so it keeps tracking the pins
  // while the rest of the block is held in reset.
  always_ff @(posedge clk) begin
    sync1_q <= led_in;
    sync2_q <= sync1_q;
  end

  assign led_s = sync2_q;
`else
  assign led_s = led_in;
`endif

  assign tick    = (div_q == DIV_W'(SAMPLE_DIV - 1));
  // Power-of-two window: all-ones count is the last sample of the window
  assign win_end = tick && (&cnt_q);

  // Sample-rate divider and window sample counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        cnt_q <= cnt_q + LOG2_W'(1);
      end
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    logic lit;

    assign lit       = ~led_s[i];
    // acc_d includes the current sample, so at window end it is the full count
    assign acc_d[i]  = acc_q[i] + ACC_W'(lit);
    // Top bit only set at 100 % duty; clamp instead of wrapping to zero
    assign scaled[i] = acc_d[i][LOG2_W] ? {OUT_W{1'b1}}
                                        : OUT_W'(acc_d[i] >> SHIFT);

    // Per-channel on-time accumulator, restarted right after window end
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        acc_q[i] <= '0;
      end else if (tick) begin
        acc_q[i] <= win_end ? '0 : acc_d[i];
      end
    end
  end

  // Output hold register: loads on window end when free or being drained,
  // otherwise drops the result and flags a sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (win_end) begin
            red_q   <= scaled[CH_R];
            green_q <= scaled[CH_G];
            blue_q  <= scaled[CH_B];
            state_q <= FULL;
            valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (win_end) begin
            if (color_ready) begin
              red_q   <= scaled[CH_R];
              green_q <= scaled[CH_G];
              blue_q  <= scaled[CH_B];
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (color_ready) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign color_valid = valid_q;
  assign overrun     = overrun_q;

endmodule
`default_nettype wire
